cpu_clock_ctrl: RTL
===================

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of clk_in cycles step_btn must be stable before a level change is accepted; legal range 2 to 2^24.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the only clock (board oscillator); all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port clk_div_in, input, 1 bit: divided square wave from the frequency divider, asynchronous to clk_in.
REQ-005 The block SHALL have port run_sw, input, 1 bit: mode switch, 1 = free-run, 0 = single-step; asynchronous.
REQ-006 The block SHALL have port step_btn, input, 1 bit: raw push-button, active-high, bouncing, asynchronous.
REQ-007 The block SHALL have port halt_in, input, 1 bit: CPU halt request, synchronous to clk_in.
REQ-008 The block SHALL have port cpu_en, output, 1 bit: one-clk_in-cycle CPU advance strobe.
REQ-009 The block SHALL have port halted, output, 1 bit: high while in HALTED.
REQ-010 The block SHALL have port cycle_count, output, 32 bits: number of cpu_en strobes issued.

Function
REQ-011 clk_div_in, run_sw and step_btn SHALL each pass through a 2-flop synchronizer before use.
REQ-012 A tick SHALL be the rising edge of synchronized clk_div_in; cpu_en SHALL be registered, going high after the 3rd clk_in rising edge, counting the first edge that samples clk_div_in high as edge 1.
REQ-013 The debouncer SHALL count consecutive cycles where the synchronized button differs from the debounced level, clear the count on any agreement, and update the debounced level when the count reaches DEBOUNCE_CYCLES-1.
REQ-014 A step pulse SHALL be a 0->1 transition of the debounced level; release (1->0) SHALL generate nothing.
REQ-015 The FSM SHALL have states STEP_WAIT, RUN, HALTED.
REQ-016 In STEP_WAIT, the FSM SHALL go to RUN when synchronized run_sw=1; otherwise each step pulse SHALL produce exactly one cpu_en, and ticks SHALL be ignored.
REQ-017 In RUN, the FSM SHALL go to STEP_WAIT when synchronized run_sw=0; otherwise each tick SHALL produce exactly one cpu_en, and step pulses SHALL be ignored.
REQ-018 halt_in=1 in STEP_WAIT or RUN SHALL go to HALTED on the next edge; HALTED SHALL be left only by reset.
REQ-019 Simultaneous events: halt_in SHALL win over a tick or step pulse in the same cycle (no cpu_en); a mode change and an event in the same cycle SHALL be evaluated in the old state.
REQ-020 cpu_en SHALL never be high in two consecutive cycles, and SHALL be 0 whenever halted=1.
REQ-021 cycle_count SHALL increment by 1 in the cycle after each cpu_en and wrap from 0xFFFFFFFF to 0.

Reset
REQ-022 rst_n low SHALL immediately clear all synchronizers, the debounce counter and debounced level, cpu_en, halted and cycle_count to 0, and set the state to STEP_WAIT.
REQ-023 Reset asserted mid-debounce or mid-strobe SHALL abort the operation with no residual pulse after release.
REQ-024 Reset deassertion is external-synchronized; the first tick or step after release SHALL be treated as a normal event.

Configuration
REQ-025 With CYCLE_COUNTER_EN defined, cycle_count SHALL behave per REQ-021.
REQ-026 Without CYCLE_COUNTER_EN, cycle_count SHALL be constant 0 with no counter register synthesized; all other behaviour is unchanged.

Structure
REQ-027 Package clk_ctrl_pkg SHALL hold the state typedef (STEP_WAIT=2'b00, RUN=2'b01, HALTED=2'b10) and constant DEBOUNCE_DEFAULT=500000.
REQ-028 Sub-module button_debounce SHALL contain the step_btn synchronizer, debounce counter and rising-edge pulse generator, parameterized by DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4, CYCLE_COUNTER_EN defined)
REQ-029 Free-run: run_sw=1, clk_div_in toggling every 10 cycles for 5 rising edges -> 5 single-cycle cpu_en pulses, each 3 cycles after its edge; cycle_count=5.
REQ-030 Bounce: run_sw=0, step_btn toggled 1/0 every 2 cycles for 12 cycles, then held 1 for 10 cycles -> exactly one cpu_en; cycle_count=1.
REQ-031 Halt priority: halt_in=1 in the same cycle as the tick-derived cpu_en request -> no cpu_en, halted=1 next cycle; further ticks and steps give no cpu_en.
REQ-032 Mode ignore: in STEP_WAIT with 3 ticks -> no cpu_en; in RUN with step presses -> no extra cpu_en beyond the tick count.
REQ-033 Wrap: force cycle_count to 0xFFFFFFFF, issue one step -> cycle_count=0.
REQ-034 Reset mid-debounce: rst_n low for 1 cycle after 2 stable button-high cycles, then button held -> state STEP_WAIT, counts restart, and one cpu_en occurs 4 or more cycles after release.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    STEP_WAIT = 2'b00,
    RUN       = 2'b01,
    HALTED    = 2'b10
  } state_t;

  localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/button_debounce.sv
// Step button path: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press (releases produce nothing).
module button_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic step_btn,
  output logic step_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       btn_sync;
  logic             level;
  logic             pulse;
  logic [CNT_W-1:0] count;
  logic             btn_s;

  assign btn_s      = btn_sync[1];
  assign step_pulse = pulse;

  // Any sample agreeing with the accepted level restarts the stability window.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b00;
      level    <= 1'b0;
      pulse    <= 1'b0;
      count    <= '0;
    end else begin
      btn_sync <= {btn_sync[0], step_btn};
      pulse    <= 1'b0;
      if (btn_s != level) begin
        if (count == CNT_LAST) begin
          level <= btn_s;
          count <= '0;
          pulse <= btn_s;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU advance-strobe generator: free-run from a divided clock or single-step
// from a debounced button, with sticky halt. CYCLE_COUNTER_EN adds a strobe counter.
module cpu_clock_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        clk_div_in,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_in,
  output logic        cpu_en,
  output logic        halted,
  output logic [31:0] cycle_count
);

  logic [2:0] div_sync;
  logic [1:0] run_sync;
  logic       tick;
  logic       run_mode;
  logic       step_pulse;
  state_t     state;
  state_t     state_next;
  logic       cpu_en_next;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .step_btn  (step_btn),
    .step_pulse(step_pulse)
  );

  // div_sync[2] only remembers the previous synchronized level for edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_sync <= 3'b000;
      run_sync <= 2'b00;
    end else begin
      div_sync <= {div_sync[1:0], clk_div_in};
      run_sync <= {run_sync[0], run_sw};
    end
  end

  assign tick     = div_sync[1] & ~div_sync[2];
  assign run_mode = run_sync[1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STEP_WAIT;
      cpu_en <= 1'b0;
    end else begin
      state  <= state_next;
      cpu_en <= cpu_en_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      STEP_WAIT: begin
        if (halt_in)       state_next = HALTED;
        else if (run_mode) state_next = RUN;
      end
      RUN: begin
        if (halt_in)        state_next = HALTED;
        else if (!run_mode) state_next = STEP_WAIT;
      end
      default: state_next = HALTED;
    endcase
  end

  // Events are judged in the current state, so a mode switch never eats or doubles one.
  always_comb begin
    cpu_en_next = 1'b0;
    unique case (state)
      STEP_WAIT: cpu_en_next = step_pulse;
      RUN:       cpu_en_next = tick;
      default:   cpu_en_next = 1'b0;
    endcase
    if (halt_in || cpu_en) cpu_en_next = 1'b0;
  end

  assign halted = (state == HALTED);

`ifdef CYCLE_COUNTER_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) count_reg <= '0;
    else if (cpu_en) count_reg <= count_reg + 32'd1;
  end

  assign cycle_count = count_reg;
`else
  assign cycle_count = '0;
`endif

endmodule
